cnn_div_seq_30ns_16ns: RTL and testbench
========================================

Name: cnn_div_seq_30ns_16ns

Overview:
Iterative unsigned restoring divider, the inverse of the CNN datapath's pipelined 14x16 unsigned multiplier. It recovers a factor from a 30-bit product and a 16-bit operand, e.g. dequantisation and rescaling of accumulated conv/fc sums. It produces one quotient bit per enabled cycle and uses a valid/ready handshake on both sides, with a clock enable gating all state.

Parameters:
DIVIDEND_W, 30, dividend and quotient width
DIVISOR_W, 16, divisor and remainder width
QUOT_W, 14, narrow result width; quotient above 2^QUOT_W-1 flags overflow

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (asserted when 0)
ce  in  1  clock enable; when 0, no register changes
in_valid  in  1  operands valid
in_ready  out  1  divider can accept operands
dividend  in  DIVIDEND_W  unsigned dividend
divisor  in  DIVISOR_W  unsigned divisor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
quotient  out  DIVIDEND_W  unsigned quotient
remainder  out  DIVISOR_W  unsigned remainder
overflow  out  1  quotient > 2^QUOT_W-1
div_by_zero  out  1  divisor was 0

Behaviour:
- Reset (reset==0 at a clk edge; takes priority over ce): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, overflow=0, div_by_zero=0, step counter=0. Reset mid-run discards the operation and produces no output.
- All non-reset updates happen only on edges where ce=1.
- States are IDLE, RUN and DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE -> RUN: on in_valid & in_ready & ce, latch divisor, load the shift register with dividend, clear the partial remainder (DIVISOR_W+1 bits) and set count=0.
- IDLE -> DONE directly when the accepted divisor==0. Outputs: quotient all ones, remainder=dividend[DIVISOR_W-1:0], div_by_zero=1, overflow=1. out_valid is first visible after the edge following acceptance.
- RUN step, one per ce edge:
  - Shift the partial remainder left by one, bringing in the dividend MSB.
  - If the result is >= divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - count increments. After step DIVIDEND_W (count==DIVIDEND_W-1 on that edge), go to DONE.
- Latency: with ce held high and acceptance on edge T0, out_valid is first high after edge T0+DIVIDEND_W (30). Each ce=0 cycle adds one cycle.
- DONE: outputs are stable while out_valid=1. On out_valid & out_ready & ce, go to IDLE and drop out_valid. in_ready rises in the same cycle, so there is no same-cycle accept (throughput 1 per DIVIDEND_W+2 cycles).
- overflow = |quotient[DIVIDEND_W-1:QUOT_W]. It is registered with the final step and valid whenever out_valid=1.
- Invariant for divisor!=0: dividend == quotient*divisor + remainder, and remainder < divisor.
- in_valid while busy is ignored; operands are not buffered. The sender must hold in_valid and operands until in_ready.
- Input changes during RUN do not affect the result, because the operands are latched.

Decomposition:
- Shared package cnn_div_pkg holds:
  - widths DIVIDEND_W=30, DIVISOR_W=16, QUOT_W=14;
  - the state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - counter width CNT_W=$clog2(DIVIDEND_W).
- One natural sub-module, cnn_div_step: a combinational single restoring step. Inputs are partial remainder, next dividend bit and divisor; outputs are the new partial remainder and the quotient bit. It is instantiated once and reused every cycle.

Test Plan:
- Exact divide: dividend=70077626 (1234*56789), divisor=56789, ce=1 -> after 30 cycles quotient=1234, remainder=0, overflow=0, div_by_zero=0.
- Remainder case: dividend=70077627, divisor=56789 -> quotient=1234, remainder=1. Also dividend=5, divisor=7 -> quotient=0, remainder=5.
- Overflow and extremes: dividend=0x3FFFFFFF, divisor=1 -> quotient=0x3FFFFFFF, remainder=0, overflow=1. Dividend=0x3FFFFFFF, divisor=0xFFFF -> quotient=16384, remainder=16383, overflow=1.
- Divide by zero: dividend=100, divisor=0 -> out_valid after 1 cycle, quotient=0x3FFFFFFF, remainder=100, div_by_zero=1, overflow=1.
- Stall and backpressure: ce=0 for 5 cycles mid-RUN -> out_valid arrives after 35 cycles with the same result. Hold out_ready=0 for 10 cycles -> outputs stable and in_ready=0 throughout. Release -> IDLE next edge.
- Reset mid-run: reset=0 at step 12 -> all outputs return to reset values next edge with no out_valid. A new operation 1000/3 then gives quotient=333, remainder=1.

Source files
------------

// File: rtl/cnn_div_pkg.sv
// Shared widths and state encoding for the sequential 30/16 unsigned divider.
// Imported by the divider top and its single-step datapath.
package cnn_div_pkg;

  localparam int DIVIDEND_W = 30;
  localparam int DIVISOR_W  = 16;
  localparam int QUOT_W     = 14;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cnn_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and emit the resulting quotient bit.
module cnn_div_step
  import cnn_div_pkg::*;
(
  input  logic [DIVISOR_W:0]   i_rem,
  input  logic                 i_bit,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic [DIVISOR_W:0]   o_rem,
  output logic                 o_qbit
);

  logic [DIVISOR_W+1:0] w_shifted;
  logic [DIVISOR_W:0]   w_diff;

  assign w_shifted = {i_rem, i_bit};
  assign o_qbit    = (w_shifted >= {2'b00, i_divisor});
  // The partial remainder stays below the divisor, so a fitting subtraction
  // always lands inside DIVISOR_W+1 bits and the narrower difference suffices.
  assign w_diff    = w_shifted[DIVISOR_W:0] - {1'b0, i_divisor};
  assign o_rem     = o_qbit ? w_diff : w_shifted[DIVISOR_W:0];

endmodule

// File: rtl/cnn_div_seq_30ns_16ns.sv
// Iterative unsigned restoring divider, 30-bit dividend by 16-bit divisor,
// one quotient bit per enabled cycle with valid/ready on both sides.
module cnn_div_seq_30ns_16ns
  import cnn_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  overflow,
  output logic                  div_by_zero
);

  state_e                r_state;
  state_e                w_next;
  logic [DIVISOR_W-1:0]  r_divisor;
  logic [DIVIDEND_W-1:0] r_shift;
  logic [DIVISOR_W:0]    r_rem;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_remainder;
  logic                  r_overflow;
  logic                  r_div_by_zero;

  logic [DIVISOR_W:0]    w_step_rem;
  logic                  w_qbit;
  logic [DIVIDEND_W-1:0] w_quot_next;
  logic                  w_zero_div;
  logic                  w_last;

  cnn_div_step u_step (
    .i_rem     (r_rem),
    .i_bit     (r_shift[DIVIDEND_W-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_qbit    (w_qbit)
  );

  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  assign w_quot_next = {r_shift[DIVIDEND_W-2:0], w_qbit};
  assign w_zero_div  = (divisor == '0);
  assign w_last      = (r_cnt == CNT_W'(DIVIDEND_W - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else if (ce) begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_zero_div ? DONE : RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_divisor     <= '0;
      r_shift       <= '0;
      r_rem         <= '0;
      r_cnt         <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else if (ce) begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_divisor <= divisor;
            r_shift   <= dividend;
            r_rem     <= '0;
            r_cnt     <= '0;
            if (w_zero_div) begin
              r_quotient    <= '1;
              r_remainder   <= dividend[DIVISOR_W-1:0];
              r_overflow    <= 1'b1;
              r_div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          r_rem   <= w_step_rem;
          r_shift <= w_quot_next;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_quotient    <= w_quot_next;
            r_remainder   <= w_step_rem[DIVISOR_W-1:0];
            r_overflow    <= |w_quot_next[DIVIDEND_W-1:QUOT_W];
            r_div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign overflow    = r_overflow;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_cnn_div_seq_30ns_16ns.sv
// Self-checking bench for cnn_div_seq_30ns_16ns: directed vector table,
// stall/backpressure/reset sequences, and random operands against a model.
module tb_cnn_div_seq_30ns_16ns;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] quotient;
  logic [15:0] remainder;
  logic        overflow;
  logic        div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  cnn_div_seq_30ns_16ns dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] dvd;
    logic [15:0] dvs;
    logic [29:0] q;
    logic [15:0] r;
    logic        ovf;
    logic        dbz;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer division, independent of any bit-serial view.
  task automatic model(input logic [29:0] a, input logic [15:0] b,
                       output logic [29:0] q, output logic [15:0] r,
                       output logic ovf, output logic dbz);
    int unsigned ua, ub, uq;
    ua = 32'(a);
    ub = 32'(b);
    if (ub == 0) begin
      q = 30'h3FFF_FFFF; r = a[15:0]; ovf = 1'b1; dbz = 1'b1;
    end else begin
      uq  = ua / ub;
      q   = uq[29:0];
      r   = 16'(ua % ub);
      ovf = (uq > 32'd16383);
      dbz = 1'b0;
    end
  endtask

  task automatic do_op(input string tag, input logic [29:0] dvd, input logic [15:0] dvs,
                       input logic [29:0] e_q, input logic [15:0] e_r,
                       input logic e_ovf, input logic e_dbz,
                       input int stall_at, input int stall_len, input int hold);
    int n;
    int lat;
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    ce       = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 30'($urandom);
    divisor  = 16'($urandom);
    check({tag, ".busy"}, {30'd0, in_ready, out_valid}, e_dbz ? 32'd1 : 32'd0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      ce = !(lat >= stall_at && lat < stall_at + stall_len);
      @(negedge clk);
      lat++;
    end
    ce = 1'b1;
    check({tag, ".latency"}, 32'(lat), e_dbz ? 32'd0 : 32'(30 + stall_len));
    check({tag, ".quotient"}, 32'(quotient), 32'(e_q));
    check({tag, ".remainder"}, 32'(remainder), 32'(e_r));
    check({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
    check({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(e_dbz));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_state"}, {30'd0, out_valid, in_ready}, 32'd2);
      check({tag, ".hold_q"}, 32'(quotient), 32'(e_q));
      check({tag, ".hold_r"}, 32'(remainder), 32'(e_r));
    end
    out_ready = 1'b1;
    ce        = 1'b0;
    @(negedge clk);
    check({tag, ".ce_gated_release"}, 32'(out_valid), 32'd1);
    ce = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".released"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] a, q;
    logic [15:0] b, r;
    logic        ovf, dbz;
    int          seen;

    vecs[0]  = '{30'd70077626,   16'd56789,  30'd1234,        16'd0,     1'b0, 1'b0};
    vecs[1]  = '{30'd70077627,   16'd56789,  30'd1234,        16'd1,     1'b0, 1'b0};
    vecs[2]  = '{30'd5,          16'd7,      30'd0,           16'd5,     1'b0, 1'b0};
    vecs[3]  = '{30'h3FFF_FFFF,  16'd1,      30'h3FFF_FFFF,   16'd0,     1'b1, 1'b0};
    vecs[4]  = '{30'h3FFF_FFFF,  16'hFFFF,   30'd16384,       16'd16383, 1'b1, 1'b0};
    vecs[5]  = '{30'd100,        16'd0,      30'h3FFF_FFFF,   16'd100,   1'b1, 1'b1};
    vecs[6]  = '{30'd16383,      16'd1,      30'd16383,       16'd0,     1'b0, 1'b0};
    vecs[7]  = '{30'd16384,      16'd1,      30'd16384,       16'd0,     1'b1, 1'b0};
    vecs[8]  = '{30'd0,          16'd5,      30'd0,           16'd0,     1'b0, 1'b0};
    vecs[9]  = '{30'h3FFF_1234,  16'd0,      30'h3FFF_FFFF,   16'h1234,  1'b1, 1'b1};
    vecs[10] = '{30'd1000,       16'd3,      30'd333,         16'd1,     1'b0, 1'b0};

    reset     = 1'b0;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    check("reset.ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
    check("reset.quotient", 32'(quotient), 32'd0);
    check("reset.remainder", 32'(remainder), 32'd0);
    check("reset.flags", {30'd0, overflow, div_by_zero}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r,
            vecs[i].ovf, vecs[i].dbz, 1000, 0, 0);
    end

    do_op("stall", 30'd70077626, 16'd56789, 30'd1234, 16'd0, 1'b0, 1'b0, 10, 5, 0);
    do_op("backpressure", 30'd70077627, 16'd56789, 30'd1234, 16'd1, 1'b0, 1'b0, 1000, 0, 10);

    // Abort an operation at step 12; reset wins even with ce low.
    @(negedge clk);
    dividend = 30'd70077626;
    divisor  = 16'd56789;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b0;
    ce    = 1'b0;
    @(negedge clk);
    check("midreset.ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
    check("midreset.quotient", 32'(quotient), 32'd0);
    check("midreset.remainder", 32'(remainder), 32'd0);
    check("midreset.flags", {30'd0, overflow, div_by_zero}, 32'd0);
    reset = 1'b1;
    ce    = 1'b1;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midreset.no_output", 32'(seen), 32'd0);
    do_op("after_reset", 30'd1000, 16'd3, 30'd333, 16'd1, 1'b0, 1'b0, 1000, 0, 0);

    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 1) == 1) ? 30'($urandom) : 30'($urandom_range(0, 1 << 20));
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 255));
        default: b = 16'($urandom_range(1, 65535));
      endcase
      model(a, b, q, r, ovf, dbz);
      do_op($sformatf("rand%0d", i), a, b, q, r, ovf, dbz,
            int'($urandom_range(0, 29)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
